// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions used by the fetch stage, the pipeline
// registers and the control unit.
//   fetch_state_t          : fetch-controller states
//   NOP_INSTR              : the all-zero instruction used for bubbles
//   OPCODE_MSB/OPCODE_LSB  : position of the opcode field in an instruction
//   OP_*                   : opcode encodings decoded by the control unit
package pipeline_pkg;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_DROP = 2'd3
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
    localparam int          OPCODE_MSB = 31;
    localparam int          OPCODE_LSB = 26;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;

endpackage

// File: rtl/if_id_reg.sv
// Pipeline register holding {valid, instr, pc4}.
//   clk, rst_n      : clock and asynchronous active-low reset
//   load_i          : capture instr_i/pc4_i as a valid instruction
//   bubble_i        : insert a bubble (valid=0, instr=NOP, pc4 kept)
//   instr_i, pc4_i  : incoming instruction and its PC+4
//   valid_o, instr_o, pc4_o : registered contents
// With neither load_i nor bubble_i the register holds. bubble_i wins over
// load_i so a flush can never be overridden by a simultaneous delivery.
module if_id_reg
    import pipeline_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int INSTR_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_i,
    input  logic               bubble_i,
    input  logic [INSTR_W-1:0] instr_i,
    input  logic [ADDR_W-1:0]  pc4_i,
    output logic               valid_o,
    output logic [INSTR_W-1:0] instr_o,
    output logic [ADDR_W-1:0]  pc4_o
);

    logic               valid_q;
    logic [INSTR_W-1:0] instr_q;
    logic [ADDR_W-1:0]  pc4_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            instr_q <= INSTR_W'(NOP_INSTR);
            pc4_q   <= '0;
        end else if (bubble_i) begin
            valid_q <= 1'b0;
            instr_q <= INSTR_W'(NOP_INSTR);
        end else if (load_i) begin
            valid_q <= 1'b1;
            instr_q <= instr_i;
            pc4_q   <= pc4_i;
        end
    end

    assign valid_o = valid_q;
    assign instr_o = instr_q;
    assign pc4_o   = pc4_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage.
// Holds the PC, fetches one word at a time from instruction memory
// (req/ready request phase, rvalid response phase, one request in flight)
// and presents the result through the IF/ID register.
//   clk, rst_n                   : clock, asynchronous active-low reset
//   imem_req/imem_addr           : fetch request and word address (= pc)
//   imem_ready                   : memory accepts the request this cycle
//   imem_rvalid/imem_rdata       : response strobe and fetched word
//   stall                        : hazard unit holds PC and IF/ID
//   redirect_valid/redirect_pc   : taken branch/jump from EX
//   if_id_valid/instr/pc4/opcode : IF/ID register contents
module instr_fetch_unit
    import pipeline_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ready,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               stall,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               if_id_valid,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic [ADDR_W-1:0]  if_id_pc4,
    output logic [5:0]         if_id_opcode
);

    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

    fetch_state_t       state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [INSTR_W-1:0] skid_q, skid_d;
    logic [ADDR_W-1:0]  pc_plus4;

    logic               ifid_load;
    logic               ifid_bubble;
    logic [INSTR_W-1:0] ifid_instr;

    assign pc_plus4 = pc_q + ADDR_W'(4);

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        skid_d      = skid_q;
        ifid_load   = 1'b0;
        ifid_bubble = 1'b0;
        ifid_instr  = imem_rdata;

        if (redirect_valid) begin
            pc_d        = redirect_pc & ALIGN_MASK;
            skid_d      = '0;
            ifid_bubble = 1'b1;
            // A request already accepted (or being accepted now) will still
            // produce a response; it must be swallowed in S_DROP.
            if ((state_q == S_WAIT && !imem_rvalid) ||
                (state_q == S_REQ  && imem_ready)   ||
                (state_q == S_DROP && !imem_rvalid)) begin
                state_d = S_DROP;
            end else begin
                state_d = S_REQ;
            end
        end else begin
            unique case (state_q)
                S_REQ: begin
                    if (imem_ready) state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        if (!stall) begin
                            ifid_load = 1'b1;
                            pc_d      = pc_plus4;
                            state_d   = S_REQ;
                        end else begin
                            skid_d  = imem_rdata;
                            state_d = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        ifid_load  = 1'b1;
                        ifid_instr = skid_q;
                        pc_d       = pc_plus4;
                        state_d    = S_REQ;
                    end
                end
                S_DROP: begin
                    if (imem_rvalid) state_d = S_REQ;
                end
                default: state_d = S_REQ;
            endcase
            // Unstalled cycle with no delivery pushes a bubble downstream.
            if (!stall && !ifid_load) ifid_bubble = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_REQ;
            pc_q    <= RESET_PC & ALIGN_MASK;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            skid_q  <= skid_d;
        end
    end

    // Gated by rst_n so no request is visible while reset is held.
    assign imem_req  = rst_n && (state_q == S_REQ);
    assign imem_addr = pc_q;

    if_id_reg #(
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W)
    ) u_if_id (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (ifid_load),
        .bubble_i (ifid_bubble),
        .instr_i  (ifid_instr),
        .pc4_i    (pc_plus4),
        .valid_o  (if_id_valid),
        .instr_o  (if_id_instr),
        .pc4_o    (if_id_pc4)
    );

    assign if_id_opcode = if_id_instr[OPCODE_MSB:OPCODE_LSB];

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_id_valid;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic [5:0]  if_id_opcode;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc4;
    } exp_t;
    exp_t exp_q[$];

    instr_fetch_unit #(
        .ADDR_W   (32),
        .INSTR_W  (32),
        .RESET_PC (32'h0)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_id_valid    (if_id_valid),
        .if_id_instr    (if_id_instr),
        .if_id_pc4      (if_id_pc4),
        .if_id_opcode   (if_id_opcode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run always ends.
    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Values seen at the most recent rising edge: an IF/ID entry is freshly
    // loaded only if the preceding cycle was neither stalled nor redirected.
    logic last_stall, last_redir;
    always @(posedge clk) begin
        last_stall <= stall;
        last_redir <= redirect_valid;
    end

    // Scoreboard: every fresh valid IF/ID entry must match the oldest
    // expected delivery.
    always @(negedge clk) begin
        if (rst_n && if_id_valid && !last_stall && !last_redir) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got instr=%h pc4=%h, expected no delivery",
                         if_id_instr, if_id_pc4);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (if_id_instr !== e.instr || if_id_pc4 !== e.pc4) begin
                    errors++;
                    $display("FAIL sb_entry: got instr=%h pc4=%h, expected instr=%h pc4=%h",
                             if_id_instr, if_id_pc4, e.instr, e.pc4);
                end
            end
        end
    end

    // Protocol monitor: rvalid only while a request is outstanding.
    logic outstanding;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outstanding <= 1'b0;
        end else begin
            if (imem_rvalid) begin
                checks++;
                if (!outstanding) begin
                    errors++;
                    $display("FAIL proto_rvalid: rvalid=1 with no outstanding request");
                end
                outstanding <= 1'b0;
            end else if (imem_req && imem_ready) begin
                outstanding <= 1'b1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        #1 rst_n = 1'b0;
        step();
        step();
        checks++;
        if (imem_req !== 1'b0 || if_id_valid !== 1'b0 || if_id_instr !== 32'h0 || if_id_pc4 !== 32'h0) begin
            errors++;
            $display("FAIL reset_state: req=%b valid=%b instr=%h pc4=%h, expected 0 0 0 0",
                     imem_req, if_id_valid, if_id_instr, if_id_pc4);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL reset_first_req: req=%b addr=%h, expected 1 00000000", imem_req, imem_addr);
        end
    endtask

    task automatic test_basic_lw();
        imem_ready = 1'b1;
        step();
        imem_ready = 1'b0;
        checks++;
        if (imem_req !== 1'b0) begin
            errors++;
            $display("FAIL basic_wait_req: req=%b, expected 0", imem_req);
        end
        imem_rvalid = 1'b1; imem_rdata = 32'h8C01_0004;
        exp_q.push_back('{32'h8C01_0004, 32'h4});
        step();
        imem_rvalid = 1'b0;
        checks++;
        if (if_id_valid !== 1'b1 || if_id_opcode !== 6'b100011 || if_id_pc4 !== 32'h4) begin
            errors++;
            $display("FAIL basic_ifid: valid=%b op=%b pc4=%h, expected 1 100011 00000004",
                     if_id_valid, if_id_opcode, if_id_pc4);
        end
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin
            errors++;
            $display("FAIL basic_next_req: req=%b addr=%h, expected 1 00000004", imem_req, imem_addr);
        end
    endtask

    task automatic test_stall_hold();
        imem_ready = 1'b1;
        stall = 1'b1;
        step();                       // now waiting for addr 4
        imem_ready = 1'b0;
        imem_rvalid = 1'b1; imem_rdata = 32'h0000_0000;
        step();                       // word parked in skid buffer
        imem_rvalid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (imem_req !== 1'b0 || if_id_valid !== 1'b1 || if_id_instr !== 32'h8C01_0004 || if_id_pc4 !== 32'h4) begin
                errors++;
                $display("FAIL stall_hold[%0d]: req=%b valid=%b instr=%h pc4=%h, expected 0 1 8c010004 00000004",
                         i, imem_req, if_id_valid, if_id_instr, if_id_pc4);
            end
            if (i == 0) step();
        end
        stall = 1'b0;
        exp_q.push_back('{32'h0000_0000, 32'h8});
        step();
        checks++;
        if (if_id_valid !== 1'b1 || if_id_opcode !== 6'b000000 || if_id_pc4 !== 32'h8 ||
            imem_req !== 1'b1 || imem_addr !== 32'h8) begin
            errors++;
            $display("FAIL stall_release: valid=%b op=%b pc4=%h req=%b addr=%h, expected 1 000000 00000008 1 00000008",
                     if_id_valid, if_id_opcode, if_id_pc4, imem_req, imem_addr);
        end
    endtask

    task automatic test_redirect_drop();
        imem_ready = 1'b1;
        step();                       // request for addr 8 accepted
        imem_ready = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'h40;
        step();
        redirect_valid = 1'b0;
        imem_rvalid = 1'b1; imem_rdata = 32'h1000_0003;
        checks++;
        if (if_id_valid !== 1'b0 || if_id_instr !== 32'h0) begin
            errors++;
            $display("FAIL redir_flush: valid=%b instr=%h, expected 0 00000000", if_id_valid, if_id_instr);
        end
        step();
        imem_rvalid = 1'b0;
        checks++;
        if (if_id_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h40) begin
            errors++;
            $display("FAIL redir_drop: valid=%b req=%b addr=%h, expected 0 1 00000040",
                     if_id_valid, imem_req, imem_addr);
        end
        imem_ready = 1'b1;
        step();
        imem_ready = 1'b0;
        imem_rvalid = 1'b1; imem_rdata = 32'h8C02_0008;
        exp_q.push_back('{32'h8C02_0008, 32'h44});
        step();
        imem_rvalid = 1'b0;
        checks++;
        if (if_id_valid !== 1'b1 || if_id_instr !== 32'h8C02_0008 || if_id_pc4 !== 32'h44) begin
            errors++;
            $display("FAIL redir_target: valid=%b instr=%h pc4=%h, expected 1 8c020008 00000044",
                     if_id_valid, if_id_instr, if_id_pc4);
        end
    endtask

    task automatic test_redirect_with_stall();
        imem_ready = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'h103;
        stall = 1'b1;
        step();
        redirect_valid = 1'b0;
        stall = 1'b0;
        checks++;
        if (if_id_valid !== 1'b0 || if_id_instr !== 32'h0 || if_id_pc4 !== 32'h44 ||
            imem_req !== 1'b1 || imem_addr !== 32'h100) begin
            errors++;
            $display("FAIL redir_stall: valid=%b instr=%h pc4=%h req=%b addr=%h, expected 0 00000000 00000044 1 00000100",
                     if_id_valid, if_id_instr, if_id_pc4, imem_req, imem_addr);
        end
    endtask

    task automatic test_ready_low();
        imem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== 32'h100 || if_id_valid !== 1'b0) begin
                errors++;
                $display("FAIL ready_low[%0d]: req=%b addr=%h valid=%b, expected 1 00000100 0",
                         i, imem_req, imem_addr, if_id_valid);
            end
        end
        imem_ready = 1'b1;
        step();
        imem_ready = 1'b0;
        imem_rvalid = 1'b1; imem_rdata = 32'h0800_0010;
        exp_q.push_back('{32'h0800_0010, 32'h104});
        step();
        imem_rvalid = 1'b0;
        checks++;
        if (if_id_valid !== 1'b1 || if_id_opcode !== 6'b000010 || if_id_pc4 !== 32'h104) begin
            errors++;
            $display("FAIL ready_low_fetch: valid=%b op=%b pc4=%h, expected 1 000010 00000104",
                     if_id_valid, if_id_opcode, if_id_pc4);
        end
    endtask

    task automatic test_pc_wrap();
        imem_ready = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin
            errors++;
            $display("FAIL wrap_req: req=%b addr=%h, expected 1 fffffffc", imem_req, imem_addr);
        end
        imem_ready = 1'b1;
        step();
        imem_ready = 1'b0;
        imem_rvalid = 1'b1; imem_rdata = 32'h1022_0003;
        exp_q.push_back('{32'h1022_0003, 32'h0});
        step();
        imem_rvalid = 1'b0;
        checks++;
        if (if_id_valid !== 1'b1 || if_id_opcode !== 6'b000100 || if_id_pc4 !== 32'h0 || imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL wrap_result: valid=%b op=%b pc4=%h addr=%h, expected 1 000100 00000000 00000000",
                     if_id_valid, if_id_opcode, if_id_pc4, imem_addr);
        end
    endtask

    task automatic test_async_reset();
        imem_ready = 1'b1;
        step();                       // request accepted, now waiting
        imem_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b0 || if_id_valid !== 1'b0 || if_id_instr !== 32'h0 || if_id_pc4 !== 32'h0) begin
            errors++;
            $display("FAIL async_reset: req=%b valid=%b instr=%h pc4=%h, expected 0 0 00000000 00000000",
                     imem_req, if_id_valid, if_id_instr, if_id_pc4);
        end
        step();
        rst_n = 1'b1;
        #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL async_reset_req: req=%b addr=%h, expected 1 00000000", imem_req, imem_addr);
        end
        imem_ready = 1'b1;
        step();
        imem_ready = 1'b0;
        imem_rvalid = 1'b1; imem_rdata = 32'h1422_0001;
        exp_q.push_back('{32'h1422_0001, 32'h4});
        step();
        imem_rvalid = 1'b0;
        checks++;
        if (if_id_valid !== 1'b1 || if_id_opcode !== 6'b000101 || if_id_pc4 !== 32'h4) begin
            errors++;
            $display("FAIL async_reset_fetch: valid=%b op=%b pc4=%h, expected 1 000101 00000004",
                     if_id_valid, if_id_opcode, if_id_pc4);
        end
    endtask

    task automatic test_scoreboard_drained();
        step();
        step();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drained: %0d entries left, expected 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic_lw();
        test_stall_hold();
        test_redirect_drop();
        test_redirect_with_stall();
        test_ready_low();
        test_pc_wrap();
        test_async_reset();
        test_scoreboard_drained();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage that produces the instruction stream whose opcode field drives the decode/control logic.
- Holds the PC and issues word fetches to instruction memory over a req/ready + rvalid handshake, with at most one request outstanding.
- Presents fetched instructions through the IF/ID pipeline register.
- Takes stall from the hazard logic and taken branch/jump redirects from EX; discards wrong-path fetches.

Parameters:
ADDR_W, 32, PC and imem address width
INSTR_W, 32, instruction width (opcode is bits [31:26])
RESET_PC, 0, first fetch address after reset

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
imem_req  out  1  fetch request valid
imem_addr  out  ADDR_W  fetch address (word aligned)
imem_ready  in  1  memory accepts request this cycle when imem_req=1
imem_rvalid  in  1  read data valid (≥1 cycle after acceptance)
imem_rdata  in  INSTR_W  fetched instruction
stall  in  1  hold IF/ID and PC (hazard unit)
redirect_valid  in  1  taken branch/jump this cycle
redirect_pc  in  ADDR_W  branch/jump target
if_id_valid  out  1  IF/ID holds a real instruction
if_id_instr  out  INSTR_W  IF/ID instruction (NOP when invalid)
if_id_pc4  out  ADDR_W  PC+4 of that instruction
if_id_opcode  out  6  if_id_instr[31:26], to control unit

Behaviour:
- Reset is asynchronous: pc=RESET_PC, state=S_REQ, if_id_valid=0, if_id_instr=NOP (all zero), if_id_pc4=0, skid buffer empty.
- imem_req=(state==S_REQ); it is low while rst_n=0. imem_addr=pc.
- pc[1:0] is always 00; redirect_pc[1:0] is ignored. pc+4 wraps modulo 2^ADDR_W.
- States: S_REQ, S_WAIT, S_HOLD, S_DROP.
- S_REQ: on imem_ready go to S_WAIT, else stay.
- S_WAIT: on rvalid with stall=0: IF/ID <= {1, rdata, pc+4}; pc <= pc+4; go to S_REQ.
- S_WAIT: on rvalid with stall=1: rdata goes to the skid buffer; go to S_HOLD.
- S_HOLD: on stall=0: IF/ID <= {1, skid, pc+4}; pc <= pc+4; go to S_REQ.
- S_DROP: on rvalid, discard the data and go to S_REQ.
- IF/ID update rule:
  - stall=1 (no redirect): IF/ID holds.
  - stall=0 and nothing delivered this cycle: bubble (valid=0, instr=NOP, pc4 holds).
- Latency: with ready=1 and rvalid the following cycle, req at t, rvalid at t+1, IF/ID valid at t+2, next req at t+2. Peak throughput is 1 instruction per 2 cycles.
- Redirect takes priority over stall and every state transition:
  - pc <= {redirect_pc[ADDR_W-1:2],00}; IF/ID flushed to bubble; skid cleared.
  - Next state: S_DROP if a request is outstanding or accepted this cycle, i.e. (S_WAIT && !rvalid) or (S_REQ && ready) or (S_DROP && !rvalid). Otherwise S_REQ.
  - Any rvalid in the redirect cycle is discarded.
- Redirect and stall in the same cycle: flush wins, IF/ID becomes a bubble.
- Back-to-back redirects: the last one wins the pc; a single outstanding response is dropped.
- rvalid outside S_WAIT/S_DROP is a protocol error and is ignored. Bench asserts it never occurs.
- Reset mid-fetch: state returns to S_REQ immediately. The memory is reset by the same rst_n, so nothing stale is returned.

Decomposition:
- Shared package pipeline_pkg:
  - fetch_state_t enum
  - NOP_INSTR
  - OPCODE_MSB/LSB
  - opcode constants OP_RTYPE=000000, OP_LW=100011, OP_SW=101011, OP_J=000010, OP_BEQ=000100, OP_BNE=000101 (shared with the control unit).
- One sub-module: if_id_reg (valid/instr/pc4 register with load/hold/flush). It is reused by later pipeline registers.

Test Plan:
- Reset release, ready=1, rvalid after 1 cycle, imem returns 0x8C010004 (LW) at addr 0 -> imem_addr=0 at first req; at t+2 if_id_valid=1, if_id_opcode=100011, if_id_pc4=4; next imem_addr=4.
- stall=1 for 3 cycles while the fetch of addr 4 returns 0x00000000 -> IF/ID holds the LW. S_HOLD buffers the word; after stall drops, IF/ID = R-type, pc4=8, no request issued during the hold.
- redirect_valid with redirect_pc=0x40 while S_WAIT, rvalid one cycle later with 0x10000003 -> that data is discarded. IF/ID is a bubble. Next imem_addr=0x40; 0x40 instruction delivered with pc4=0x44.
- redirect_pc=0x103 with stall=1 in the same cycle -> pc=0x100, IF/ID bubble.
- imem_ready low for 4 cycles -> imem_req stays 1 with a stable imem_addr; IF/ID issues bubbles.
- pc=0xFFFFFFFC fetch -> if_id_pc4=0, next imem_addr=0.
- rst_n asserted asynchronously mid-S_WAIT -> outputs reset immediately without a clock edge; first post-reset req addr=RESET_PC.
